// File: rtl/touch_pkg.sv
// Shared definitions for the touchscreen scan sequencer: FSM encoding,
// panel pin indices and the per-phase plate drive patterns.
package touch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_X,
    ST_CONV_X,
    ST_SETTLE_Y,
    ST_CONV_Y,
    ST_PUBLISH
  } state_t;

  localparam int PIN_XP = 0;
  localparam int PIN_XN = 1;
  localparam int PIN_YP = 2;
  localparam int PIN_YN = 3;

  // X phase drives xp high / xn low; Y phase drives yp high / yn low.
  localparam logic [3:0] X_OE  = (4'b0001 << PIN_XP) | (4'b0001 << PIN_XN);
  localparam logic [3:0] X_LVL = (4'b0001 << PIN_XP);
  localparam logic [3:0] Y_OE  = (4'b0001 << PIN_YP) | (4'b0001 << PIN_YN);
  localparam logic [3:0] Y_LVL = (4'b0001 << PIN_YP);

  typedef struct packed {
    logic [3:0] oe;
    logic [3:0] lvl;
    logic       chan;
  } drive_t;

  function automatic drive_t phase_drive(input state_t s);
    drive_t d;
    d = '0;
    case (s)
      ST_SETTLE_X, ST_CONV_X: begin
        d.oe   = X_OE;
        d.lvl  = X_LVL;
        d.chan = 1'b1;
      end
      ST_SETTLE_Y, ST_CONV_Y: begin
        d.oe   = Y_OE;
        d.lvl  = Y_LVL;
        d.chan = 1'b0;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/touch_axis_accum.sv
// Per-axis sample accumulator: sums 2^AVG_LOG2 conversions, flags the last
// one and presents the truncated average.
module touch_axis_accum #(
  parameter int ADC_W    = 10,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [ADC_W-1:0] sample_data,
  output logic             last_sample,
  output logic [ADC_W-1:0] average
);

  localparam int N_SAMPLES = 1 << AVG_LOG2;
  localparam int ACC_W     = ADC_W + AVG_LOG2;
  localparam int CNT_W     = AVG_LOG2 + 1;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  assign last_sample = sample_en && (count == CNT_W'(N_SAMPLES - 1));
  assign average     = acc[ACC_W-1:AVG_LOG2];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc   <= '0;
      count <= '0;
    end else if (sample_en) begin
      acc   <= acc + ACC_W'(sample_data);
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/touch_scan_sequencer.sv
// 4-wire resistive touchscreen scan sequencer: X/Y plate drive, settle,
// averaged ADC acquisition and coordinate publish. Optional TOUCH_DETECT_EN
// suppresses publishing of frames below TOUCH_MIN and adds touch_present.
module touch_scan_sequencer
  import touch_pkg::*;
#(
  parameter int ADC_W          = 10,
  parameter int AVG_LOG2       = 4,
  parameter int SETTLE_CYCLES  = 1000,
  parameter int TIMEOUT_CYCLES = 4096
`ifdef TOUCH_DETECT_EN
  , parameter int TOUCH_MIN    = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [3:0]       drv_oe,
  output logic [3:0]       drv_lvl,
  output logic             adc_req,
  output logic             adc_chan,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] x_coord,
  output logic [ADC_W-1:0] y_coord,
  output logic             coord_valid,
  output logic             adc_timeout
`ifdef TOUCH_DETECT_EN
  , output logic           touch_present
`endif
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t           state, state_next;
  drive_t           drv_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic             sample_accept, settle_done, conv_expired;
  logic             timeout_hit, publish_ok, acc_clear;
  logic             x_last, y_last;
  logic [ADC_W-1:0] x_avg, y_avg;

  // Samples are taken only while a request is outstanding.
  assign sample_accept = adc_req && adc_valid;
  assign settle_done   = cycle_cnt == CNT_W'(SETTLE_CYCLES - 1);
  assign conv_expired  = (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !sample_accept;
  assign acc_clear     = (state == ST_PUBLISH) || timeout_hit;

  touch_axis_accum #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_accum_x (
    .clk         (clk),
    .reset       (reset),
    .clear       (acc_clear),
    .sample_en   (sample_accept && (state == ST_CONV_X)),
    .sample_data (adc_data),
    .last_sample (x_last),
    .average     (x_avg)
  );

  touch_axis_accum #(.ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2)) u_accum_y (
    .clk         (clk),
    .reset       (reset),
    .clear       (acc_clear),
    .sample_en   (sample_accept && (state == ST_CONV_Y)),
    .sample_data (adc_data),
    .last_sample (y_last),
    .average     (y_avg)
  );

`ifdef TOUCH_DETECT_EN
  logic touch_ok;
  assign touch_ok   = (x_avg >= ADC_W'(TOUCH_MIN)) && (y_avg >= ADC_W'(TOUCH_MIN));
  assign publish_ok = (state == ST_PUBLISH) && touch_ok;
`else
  assign publish_ok = (state == ST_PUBLISH);
`endif

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:     if (enable) state_next = ST_SETTLE_X;
      ST_SETTLE_X: if (settle_done) state_next = ST_CONV_X;
      ST_CONV_X: begin
        if (x_last) begin
          state_next = ST_SETTLE_Y;
        end else if (conv_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_SETTLE_Y: if (settle_done) state_next = ST_CONV_Y;
      ST_CONV_Y: begin
        if (y_last) begin
          state_next = ST_PUBLISH;
        end else if (conv_expired) begin
          timeout_hit = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_PUBLISH:  state_next = enable ? ST_SETTLE_X : ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  assign drv_next = phase_drive(state_next);

  // One counter serves both settle and timeout; it restarts on every state
  // change and on every accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if ((state_next != state) || sample_accept) begin
      cycle_cnt <= '0;
    end else if (state inside {ST_SETTLE_X, ST_CONV_X, ST_SETTLE_Y, ST_CONV_Y}) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end else begin
      cycle_cnt <= '0;
    end
  end

  // Drive outputs are decoded from the next state so pins move on the same
  // edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      drv_oe      <= '0;
      drv_lvl     <= '0;
      adc_chan    <= 1'b0;
      adc_req     <= 1'b0;
      adc_timeout <= 1'b0;
      coord_valid <= 1'b0;
      x_coord     <= '0;
      y_coord     <= '0;
    end else begin
      state       <= state_next;
      drv_oe      <= drv_next.oe;
      drv_lvl     <= drv_next.lvl;
      adc_chan    <= drv_next.chan;
      adc_req     <= (state_next == ST_CONV_X) || (state_next == ST_CONV_Y);
      adc_timeout <= timeout_hit;
      coord_valid <= publish_ok;
      if (publish_ok) begin
        x_coord <= x_avg;
        y_coord <= y_avg;
      end
    end
  end

`ifdef TOUCH_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      touch_present <= 1'b0;
    end else if (state == ST_PUBLISH) begin
      touch_present <= touch_ok;
    end
  end
`endif

endmodule

// File: doc/touch_scan_sequencer.md
Name: touch_scan_sequencer

Overview:
Upstream acquisition stage for the 4-wire resistive touchscreen. It drives the panel plates in alternating X/Y phases and waits a settle time per phase. It requests ADC conversions through a req/valid handshake, accumulates 2^AVG_LOG2 samples per axis, and publishes averaged x/y coordinates with a one-cycle valid pulse to the ball-position consumer.

Parameters:
ADC_W, 10, ADC sample width and coordinate width
AVG_LOG2, 4, log2 of samples averaged per axis (16)
SETTLE_CYCLES, 1000, clk cycles between plate drive change and first conversion (10 us at 100 MHz)
TIMEOUT_CYCLES, 4096, max cycles adc_req may stay high without adc_valid
TOUCH_MIN, 32, minimum averaged sense reading counted as a touch (TOUCH_DETECT_EN only)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
enable  input  1  level; while high, frames run back-to-back
drv_oe  output  4  pin output enables {yn,yp,xn,xp}; 0 = high-Z
drv_lvl  output  4  pin drive levels {yn,yp,xn,xp}
adc_req  output  1  conversion request; held until adc_valid
adc_chan  output  1  sense channel: 1 = yp pin (X phase), 0 = xp pin (Y phase)
adc_valid  input  1  one-cycle pulse; adc_data valid this cycle
adc_data  input  ADC_W  conversion result
x_coord  output  ADC_W  averaged X, held between frames
y_coord  output  ADC_W  averaged Y, held between frames
coord_valid  output  1  one-cycle pulse on new x/y pair
adc_timeout  output  1  one-cycle pulse when a frame is aborted on timeout

Behaviour:
- Reset: state IDLE. drv_oe=0, drv_lvl=0, adc_req=0, adc_chan=0, x_coord=0, y_coord=0, coord_valid=0, adc_timeout=0. Accumulators, sample counter, settle counter and timeout counter cleared. Reset mid-frame aborts the frame with no publish.
- States: IDLE -> SETTLE_X -> CONV_X -> SETTLE_Y -> CONV_Y -> PUBLISH -> (SETTLE_X if enable, else IDLE).
- IDLE: all pins high-Z. Moves to SETTLE_X on the first cycle enable=1.
- X phase (SETTLE_X, CONV_X): drv_oe=4'b0011, drv_lvl=4'b0001 (xp high, xn low), adc_chan=1.
- Y phase (SETTLE_Y, CONV_Y): drv_oe=4'b1100, drv_lvl=4'b0100 (yp high, yn low), adc_chan=0.
- Drive outputs are registered and change on the same edge as the state change.
- SETTLE_*: counts SETTLE_CYCLES cycles from entry, then enters CONV_*. adc_req=0 throughout.
- CONV_*: adc_req=1 from the entry cycle.
  - On adc_valid: adc_data is added to that axis accumulator (width ADC_W+AVG_LOG2, no overflow possible) and the sample count increments.
  - adc_req stays high for the next sample unless this was sample 2^AVG_LOG2. After the last sample, adc_req drops the following cycle and the state advances.
  - adc_valid while adc_req=0 is ignored.
- Timeout: the counter restarts on entry to CONV_* and on each adc_valid. If it reaches TIMEOUT_CYCLES:
  - pulse adc_timeout for one cycle;
  - clear both accumulators;
  - release pins to high-Z;
  - go to IDLE. x_coord/y_coord keep their old values.
- PUBLISH (one cycle): x_coord <= accX >> AVG_LOG2 and y_coord <= accY >> AVG_LOG2 (truncating), both updated the same edge. coord_valid=1 for exactly this cycle. Accumulators and counters cleared. Pins high-Z.
- enable deasserted mid-frame: the current frame completes and publishes, then the block returns to IDLE.
- Frame latency with an ideal ADC (valid 1 cycle after req) is at most 2*(SETTLE_CYCLES + 2*2^AVG_LOG2 + 2) + 2 cycles.

Optional Feature:
TOUCH_DETECT_EN defined:
- At PUBLISH, if either averaged value < TOUCH_MIN, coord_valid stays 0 and x_coord/y_coord hold their old values.
- Adds output touch_present (1 bit, reset 0), updated at each PUBLISH to indicate both averages >= TOUCH_MIN.

TOUCH_DETECT_EN undefined:
- Every completed frame publishes.
- touch_present port is absent.

Decomposition:
- Shared package touch_pkg: state encoding, pin index constants PIN_XP=0, PIN_XN=1, PIN_YP=2, PIN_YN=3, and phase drive masks.
- One sub-module is natural: touch_axis_accum (accumulate, count, done flag, shift-average). Instantiate it once per axis.

Test Plan:
- Ideal ADC (valid 1 cycle after req) returns 100 in the X phase and 200 in the Y phase -> one coord_valid pulse with x_coord=100, y_coord=200. Check drv_oe/drv_lvl per phase and that no adc_req is asserted during settle.
- X samples alternating 100/103 over 16 samples -> accumulator 1624, x_coord=101 (truncation).
- ADC never asserts adc_valid in CONV_X -> adc_timeout pulses exactly TIMEOUT_CYCLES after CONV_X entry; state IDLE; coords unchanged; no coord_valid.
- Reset asserted during CONV_Y after 7 samples, then released with enable=1 -> next frame starts at SETTLE_X with empty accumulators and publishes correct averages.
- enable dropped during SETTLE_Y -> frame publishes once, then pins go high-Z and no further adc_req is issued.
- With TOUCH_DETECT_EN: X samples all 10 (< TOUCH_MIN=32) -> no coord_valid; touch_present=0; coords held.
